// File: rtl/int_sequencer.sv
// -----------------------------------------------------------------------------
// int_sequencer
//
// Interrupt entry/exit controller for the 5-stage pipeline. It latches a rising
// edge on the external interrupt and waits for a safe point (no control
// transfer in flight). It then stalls fetch, drains the pipeline with NOPs,
// pushes the PC and then the CCR through the memory stage, and redirects fetch
// to the interrupt vector. Further entries are held off until RTI retires.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_int          external interrupt request (level, edge-acted)
//   i_safe_point   decode/execute hold no jump/call/return/pop-PC/pop-CCR
//   i_pc_current   PC of next unexecuted instruction
//   i_ccr          current flag register
//   i_push_ack     memory stage accepted the current push
//   i_rti_done     one-cycle pulse when RTI's pop-PC writes back
//   o_fetch_stall  freezes PC and fetch/decode register
//   o_inject_nop   forces NOP opcode into the control unit mux
//   o_push_pc_req  push saved_pc[15:0] request
//   o_push_ccr_req push saved_ccr request
//   o_push_data    data for the active push
//   o_pc_load      one-cycle PC redirect strobe
//   o_pc_load_addr redirect target
//   o_int_active   handler running
//   o_int_lost     sticky: edge arrived while a request was already pending
// -----------------------------------------------------------------------------
module int_sequencer #(
   parameter int              PC_W         = 32,
   parameter logic [PC_W-1:0] INT_VECTOR   = '0,
   parameter int              DRAIN_CYCLES = 3
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_int,
   input  logic            i_safe_point,
   input  logic [PC_W-1:0] i_pc_current,
   input  logic [2:0]      i_ccr,
   input  logic            i_push_ack,
   input  logic            i_rti_done,
   output logic            o_fetch_stall,
   output logic            o_inject_nop,
   output logic            o_push_pc_req,
   output logic            o_push_ccr_req,
   output logic [15:0]     o_push_data,
   output logic            o_pc_load,
   output logic [PC_W-1:0] o_pc_load_addr,
   output logic            o_int_active,
   output logic            o_int_lost
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DRAIN    = 3'd1;
   localparam logic [2:0] S_PUSH_PC  = 3'd2;
   localparam logic [2:0] S_PUSH_CCR = 3'd3;
   localparam logic [2:0] S_VECTOR   = 3'd4;
   localparam logic [2:0] S_ACTIVE   = 3'd5;

   localparam int              CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   logic [2:0]       r_state;
   logic             r_int_q;
   logic             r_pending;
   logic [15:0]      r_saved_pc;
   logic [2:0]       r_saved_ccr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_int_lost;
   logic             w_rise;

   // Only the low half-word of the PC is ever pushed.
   generate
      if (PC_W > 16) begin : g_pc_hi
         logic w_unused_pc_hi;
         assign w_unused_pc_hi = ^i_pc_current[PC_W-1:16];
      end
   endgenerate

   assign w_rise = i_int & ~r_int_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_int_q     <= 1'b0;
         r_pending   <= 1'b0;
         r_saved_pc  <= '0;
         r_saved_ccr <= '0;
         r_cnt       <= '0;
         r_int_lost  <= 1'b0;
      end else begin
         r_int_q <= i_int;

         // A second edge before the first is serviced cannot be queued.
         if (w_rise && r_pending)
            r_int_lost <= 1'b1;

         // Clearing on VECTOR wins: an edge landing in that cycle is counted
         // as lost above since the request was still pending.
         if (r_state == S_VECTOR)
            r_pending <= 1'b0;
         else if (w_rise)
            r_pending <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (r_pending && i_safe_point) begin
                  r_state     <= S_DRAIN;
                  r_saved_pc  <= i_pc_current[15:0];
                  r_saved_ccr <= i_ccr;
                  r_cnt       <= DRAIN_LOAD;
               end
            end
            S_DRAIN: begin
               if (r_cnt == '0)
                  r_state <= S_PUSH_PC;
               else
                  r_cnt <= r_cnt - 1'b1;
            end
            S_PUSH_PC: begin
               if (i_push_ack)
                  r_state <= S_PUSH_CCR;
            end
            S_PUSH_CCR: begin
               if (i_push_ack)
                  r_state <= S_VECTOR;
            end
            S_VECTOR: begin
               r_state <= S_ACTIVE;
            end
            S_ACTIVE: begin
               if (i_rti_done)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode purely from registers, so reset clears them immediately.
   always_comb begin
      o_fetch_stall  = 1'b0;
      o_inject_nop   = 1'b0;
      o_push_pc_req  = 1'b0;
      o_push_ccr_req = 1'b0;
      o_push_data    = 16'h0000;
      o_pc_load      = 1'b0;
      o_pc_load_addr = '0;
      o_int_active   = 1'b0;
      case (r_state)
         S_DRAIN: begin
            o_fetch_stall = 1'b1;
            o_inject_nop  = 1'b1;
         end
         S_PUSH_PC: begin
            o_fetch_stall = 1'b1;
            o_inject_nop  = 1'b1;
            o_push_pc_req = 1'b1;
            o_push_data   = r_saved_pc;
         end
         S_PUSH_CCR: begin
            o_fetch_stall  = 1'b1;
            o_inject_nop   = 1'b1;
            o_push_ccr_req = 1'b1;
            o_push_data    = {13'b0, r_saved_ccr};
         end
         S_VECTOR: begin
            o_inject_nop   = 1'b1;
            o_pc_load      = 1'b1;
            o_pc_load_addr = INT_VECTOR;
         end
         S_ACTIVE: begin
            o_int_active = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign o_int_lost = r_int_lost;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

   localparam int PC_W = 32;

   logic            clk;
   logic            reset;
   logic            irq;
   logic            safe_point;
   logic [PC_W-1:0] pc_current;
   logic [2:0]      ccr;
   logic            push_ack;
   logic            rti_done;
   logic            fetch_stall;
   logic            inject_nop;
   logic            push_pc_req;
   logic            push_ccr_req;
   logic [15:0]     push_data;
   logic            pc_load;
   logic [PC_W-1:0] pc_load_addr;
   logic            int_active;
   logic            int_lost;

   int n_checks = 0;
   int n_fail   = 0;

   int_sequencer #(
      .PC_W         (PC_W),
      .INT_VECTOR   ('0),
      .DRAIN_CYCLES (3)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_int          (irq),
      .i_safe_point   (safe_point),
      .i_pc_current   (pc_current),
      .i_ccr          (ccr),
      .i_push_ack     (push_ack),
      .i_rti_done     (rti_done),
      .o_fetch_stall  (fetch_stall),
      .o_inject_nop   (inject_nop),
      .o_push_pc_req  (push_pc_req),
      .o_push_ccr_req (push_ccr_req),
      .o_push_data    (push_data),
      .o_pc_load      (pc_load),
      .o_pc_load_addr (pc_load_addr),
      .o_int_active   (int_active),
      .o_int_lost     (int_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {stall, nop, pc_req, ccr_req, pc_load, active}
   function automatic logic [5:0] obs();
      return {fetch_stall, inject_nop, push_pc_req, push_ccr_req, pc_load, int_active};
   endfunction

   task automatic do_reset();
      reset      = 1'b1;
      irq        = 1'b0;
      safe_point = 1'b0;
      pc_current = '0;
      ccr        = 3'b000;
      push_ack   = 1'b0;
      rti_done   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_pcreq(input string tag, input int maxc);
      int c;
      c = 0;
      while (!push_pc_req && c < maxc) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (!push_pc_req) begin
         n_fail++;
         $display("FAIL %s: push_pc_req timeout got=%0b want=1", tag, push_pc_req);
      end
   endtask

   task automatic wait_active(input string tag, input int maxc);
      int c;
      c = 0;
      while (!int_active && c < maxc) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (!int_active) begin
         n_fail++;
         $display("FAIL %s: int_active timeout got=%0b want=1", tag, int_active);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      irq = 1'b0; safe_point = 1'b0; pc_current = '0; ccr = '0;
      push_ack = 1'b0; rti_done = 1'b0;
      #1;
      n_checks++;
      if ({obs(), push_data, pc_load_addr, int_lost} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got=%b/%h/%h/%b want=0", obs(), push_data, pc_load_addr, int_lost);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({obs(), int_lost} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got=%b want=0", {obs(), int_lost});
      end
      $display("test_reset done");
   endtask

   task automatic test_basic_entry();
      logic [5:0]  exp_o [8];
      logic [15:0] exp_d [8];
      exp_o = '{6'b000000, 6'b110000, 6'b110000, 6'b110000,
                6'b111000, 6'b110100, 6'b010010, 6'b000001};
      exp_d = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0123, 16'h0005, 16'h0, 16'h0};
      do_reset();
      irq = 1'b1; safe_point = 1'b1; pc_current = 32'h0000_0123;
      ccr = 3'b101; push_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs() !== exp_o[i] || push_data !== exp_d[i] || pc_load_addr !== '0) begin
            n_fail++;
            $display("FAIL basic_cycle%0d: got=%b data=%h addr=%h want=%b data=%h addr=0",
                     i, obs(), push_data, pc_load_addr, exp_o[i], exp_d[i]);
         end
         $display("basic cycle %0d obs=%b data=%h", i, obs(), push_data);
      end
   endtask

   task automatic test_safe_point_wait();
      do_reset();
      push_ack = 1'b1;
      pc_current = 32'h0000_0111;
      irq = 1'b1;
      rti_done = 1'b1;  // ignored outside ACTIVE
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rti_done = 1'b0;
         pc_current = pc_current + 32'h1;
         n_checks++;
         if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL unsafe_hold%0d: got=%b want=000000", i, obs());
         end
      end
      pc_current = 32'hABCD_0456;
      safe_point = 1'b1;
      @(negedge clk);
      pc_current = 32'h0000_0999;
      n_checks++;
      if (obs() !== 6'b110000) begin
         n_fail++;
         $display("FAIL safe_enter: got=%b want=110000", obs());
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (push_pc_req !== 1'b1 || push_data !== 16'h0456) begin
         n_fail++;
         $display("FAIL saved_pc: req=%b data=%h want req=1 data=0456", push_pc_req, push_data);
      end
      $display("safe_point wait: push_data=%h", push_data);
   endtask

   task automatic test_push_ack_delay();
      do_reset();
      push_ack = 1'b0;
      irq = 1'b1; safe_point = 1'b1; pc_current = 32'h0000_7A5C; ccr = 3'b010;
      wait_pcreq("ack_delay", 10);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (push_pc_req !== 1'b1 || push_ccr_req !== 1'b0 || push_data !== 16'h7A5C) begin
            n_fail++;
            $display("FAIL ack_hold%0d: pc=%b ccr=%b data=%h want 1/0/7a5c",
                     k, push_pc_req, push_ccr_req, push_data);
         end
         if (k == 2) push_ack = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (push_pc_req !== 1'b0 || push_ccr_req !== 1'b1 || push_data !== 16'h0002) begin
         n_fail++;
         $display("FAIL ack_to_ccr: pc=%b ccr=%b data=%h want 0/1/0002",
                  push_pc_req, push_ccr_req, push_data);
      end
      wait_active("ack_delay_active", 5);
      $display("push_ack delay done");
   endtask

   // Continues from ACTIVE left by test_push_ack_delay.
   task automatic test_back_to_back();
      irq = 1'b0;
      @(negedge clk);
      irq = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (obs() !== 6'b000001) begin
            n_fail++;
            $display("FAIL active_hold: got=%b want=000001", obs());
         end
      end
      rti_done = 1'b1;
      @(negedge clk);
      rti_done = 1'b0;
      n_checks++;
      if (obs() !== 6'b000000) begin
         n_fail++;
         $display("FAIL rti_idle: got=%b want=000000", obs());
      end
      @(negedge clk);
      n_checks++;
      if (obs() !== 6'b110000 || int_lost !== 1'b0) begin
         n_fail++;
         $display("FAIL reentry: got=%b lost=%b want=110000 lost=0", obs(), int_lost);
      end
      wait_active("reentry_active", 12);
      $display("back_to_back reentry done lost=%b", int_lost);
   endtask

   task automatic test_int_lost();
      int loads;
      do_reset();
      push_ack = 1'b1;
      for (int r = 0; r < 3; r++) begin
         irq = 1'b1; @(negedge clk);
         irq = 1'b0; @(negedge clk);
      end
      n_checks++;
      if (int_lost !== 1'b1 || fetch_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL lost_set: lost=%b stall=%b want lost=1 stall=0", int_lost, fetch_stall);
      end
      safe_point = 1'b1;
      loads = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pc_load) loads++;
      end
      n_checks++;
      if (loads !== 1 || int_active !== 1'b1) begin
         n_fail++;
         $display("FAIL lost_single_entry: loads=%0d active=%b want 1/1", loads, int_active);
      end
      rti_done = 1'b1;
      @(negedge clk);
      rti_done = 1'b0;
      loads = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fetch_stall) loads++;
      end
      n_checks++;
      if (loads !== 0 || int_lost !== 1'b1) begin
         n_fail++;
         $display("FAIL lost_no_reentry: stalls=%0d lost=%b want 0/1", loads, int_lost);
      end
      $display("int_lost test done lost=%b", int_lost);
   endtask

   task automatic test_reset_mid();
      do_reset();
      irq = 1'b1; safe_point = 1'b1; pc_current = 32'h0000_1234; ccr = 3'b111;
      wait_pcreq("reset_mid", 10);
      push_ack = 1'b1;
      @(negedge clk);
      push_ack = 1'b0;
      n_checks++;
      if (push_ccr_req !== 1'b1 || push_data !== 16'h0007) begin
         n_fail++;
         $display("FAIL mid_ccr: req=%b data=%h want 1/0007", push_ccr_req, push_data);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({obs(), push_data, pc_load_addr} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got=%b data=%h addr=%h want 0", obs(), push_data, pc_load_addr);
      end
      irq = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle%0d: got=%b want=000000", i, obs());
         end
      end
      $display("reset mid-sequence done");
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_safe_point_wait();
      test_push_ack_delay();
      test_back_to_back();
      test_int_lost();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
